video_mnist_result_decoder: RTL and testbench

- Consumer at the downstream end of the MNIST CNN core's output AXI4-Stream.
- Each 70-bit beat packs CLASS_NUM per-class scores for one pixel. The block reduces each beat to a class index plus a confidence flag and forwards it as a narrow pixel stream for overlay and colouring logic.
- It also accumulates a per-frame vote histogram and reports the winning digit of each completed frame on a sideband register interface.

---
 rtl/video_mnist_result_decoder.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_video_mnist_result_decoder.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mnist_result_decoder.sv
// ============================================================================
// video_mnist_result_decoder
//
// Sits at the end of the MNIST CNN output stream. Each input beat holds
// CLASS_NUM unsigned class scores for one pixel. The block turns each beat
// into {confident, class_index} and forwards it as a narrow pixel stream.
// Optionally it also builds a per-frame vote histogram and reports the
// winning digit of every completed frame.
//
// Build option:
//   VIDEO_MNIST_RESULT_DECODER_FRAME_VOTE_EN
//     defined   : histogram, shadow bank and result-scan FSM are built.
//     undefined : no vote logic; out_frame_* are tied to 0.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   param_threshold      minimum max-score for a pixel to count as confident
//   s_axi4s_*            input stream (tdata = CLASS_NUM packed scores,
//                        tuser[0] = start of frame, tlast = end of line)
//   m_axi4s_*            output stream (tdata = {confident, class_index})
//   out_frame_class      winning class of the last completed frame
//   out_frame_count      vote count of that winner
//   out_frame_valid      one-cycle pulse when out_frame_class/count update
// ============================================================================
module video_mnist_result_decoder #(
    parameter int TUSER_WIDTH   = 1,
    parameter int CLASS_NUM     = 10,
    parameter int SCORE_WIDTH   = 7,
    parameter int S_TDATA_WIDTH = CLASS_NUM * SCORE_WIDTH,
    parameter int CLASS_WIDTH   = 4,
    parameter int COUNT_WIDTH   = 20
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [SCORE_WIDTH-1:0]   param_threshold,

    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,

    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [CLASS_WIDTH:0]     m_axi4s_tdata,
    output logic                     m_axi4s_tvalid,
    input  logic                     m_axi4s_tready,

    output logic [CLASS_WIDTH-1:0]   out_frame_class,
    output logic [COUNT_WIDTH-1:0]   out_frame_count,
    output logic                     out_frame_valid
);

    localparam int PAIR_NUM = (CLASS_NUM + 1) / 2;
    localparam int PAD_NUM  = 2 * PAIR_NUM;

    // Both pipeline stages advance together; with a single enable there are
    // no bubbles and the stream runs at full rate while tready is high.
    logic cke;
    assign cke            = ~m_axi4s_tvalid | m_axi4s_tready;
    assign s_axi4s_tready = cke;

    // ------------------------------------------------------------------
    // Stage 1 combinational: pairwise reduction.
    // Scores are padded to an even count with zeros; a zero pad can never
    // strictly beat its partner, so an odd last class passes straight through.
    // Within a pair the odd index only wins when strictly greater, keeping
    // the lowest index on ties.
    // ------------------------------------------------------------------
    logic [PAD_NUM*SCORE_WIDTH-1:0] data_pad;
    logic [SCORE_WIDTH-1:0]         score_pad [PAD_NUM];
    logic [SCORE_WIDTH-1:0]         pair_score [PAIR_NUM];
    logic [CLASS_WIDTH-1:0]         pair_idx   [PAIR_NUM];

    assign data_pad = (PAD_NUM*SCORE_WIDTH)'(s_axi4s_tdata);

    always_comb begin
        for (int c = 0; c < PAD_NUM; c++) begin
            score_pad[c] = data_pad[c*SCORE_WIDTH +: SCORE_WIDTH];
        end
        for (int p = 0; p < PAIR_NUM; p++) begin
            if (score_pad[2*p+1] > score_pad[2*p]) begin
                pair_score[p] = score_pad[2*p+1];
                pair_idx[p]   = CLASS_WIDTH'(2*p+1);
            end else begin
                pair_score[p] = score_pad[2*p];
                pair_idx[p]   = CLASS_WIDTH'(2*p);
            end
        end
    end

    // Stage 1 registers: candidates plus sideband; data holds while stalled.
    logic [SCORE_WIDTH-1:0] s1_score [PAIR_NUM];
    logic [CLASS_WIDTH-1:0] s1_idx   [PAIR_NUM];
    logic                   s1_valid;
    logic [TUSER_WIDTH-1:0] s1_user;
    logic                   s1_last;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid <= 1'b0;
            s1_user  <= '0;
            s1_last  <= 1'b0;
            for (int p = 0; p < PAIR_NUM; p++) begin
                s1_score[p] <= '0;
                s1_idx[p]   <= '0;
            end
        end else if (cke) begin
            s1_valid <= s_axi4s_tvalid;
            if (s_axi4s_tvalid) begin
                s1_user <= s_axi4s_tuser;
                s1_last <= s_axi4s_tlast;
                for (int p = 0; p < PAIR_NUM; p++) begin
                    s1_score[p] <= pair_score[p];
                    s1_idx[p]   <= pair_idx[p];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: finish the argmax. Candidates are in ascending
    // index order, so a strict compare keeps the lowest index on ties.
    // ------------------------------------------------------------------
    logic [SCORE_WIDTH-1:0] best_score;
    logic [CLASS_WIDTH-1:0] best_idx;
    logic                   confident;

    always_comb begin
        best_score = s1_score[0];
        best_idx   = s1_idx[0];
        for (int p = 1; p < PAIR_NUM; p++) begin
            if (s1_score[p] > best_score) begin
                best_score = s1_score[p];
                best_idx   = s1_idx[p];
            end
        end
        confident = (best_score >= param_threshold);
    end

    // Stage 2 registers drive the output stream directly.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi4s_tvalid <= 1'b0;
            m_axi4s_tdata  <= '0;
            m_axi4s_tuser  <= '0;
            m_axi4s_tlast  <= 1'b0;
        end else if (cke) begin
            m_axi4s_tvalid <= s1_valid;
            if (s1_valid) begin
                m_axi4s_tdata <= {confident, best_idx};
                m_axi4s_tuser <= s1_user;
                m_axi4s_tlast <= s1_last;
            end
        end
    end

`ifdef VIDEO_MNIST_RESULT_DECODER_FRAME_VOTE_EN

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    logic                   out_hs;
    logic                   vote;
    logic                   snapshot;
    logic [CLASS_WIDTH-1:0] pix_class;

    assign out_hs    = m_axi4s_tvalid & m_axi4s_tready;
    assign vote      = out_hs & m_axi4s_tdata[CLASS_WIDTH];
    assign snapshot  = out_hs & m_axi4s_tuser[0];
    assign pix_class = m_axi4s_tdata[CLASS_WIDTH-1:0];

    logic [COUNT_WIDTH-1:0] hist   [CLASS_NUM];
    logic [COUNT_WIDTH-1:0] shadow [CLASS_NUM];

    // Live histogram and shadow bank. On a start-of-frame handshake the
    // finished frame moves to the shadow bank and the live bank restarts
    // with only the SOF pixel's own vote, so that pixel lands in the new frame.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int c = 0; c < CLASS_NUM; c++) begin
                hist[c]   <= '0;
                shadow[c] <= '0;
            end
        end else if (snapshot) begin
            for (int c = 0; c < CLASS_NUM; c++) begin
                shadow[c] <= hist[c];
                hist[c]   <= (vote && (pix_class == CLASS_WIDTH'(c))) ?
                             COUNT_WIDTH'(1) : '0;
            end
        end else if (vote) begin
            if (hist[pix_class] != '1) begin
                hist[pix_class] <= hist[pix_class] + 1'b1;
            end
        end
    end

    state_t                 state;
    state_t                 state_next;
    logic [CLASS_WIDTH-1:0] idx;
    logic [CLASS_WIDTH-1:0] best_class;
    logic [COUNT_WIDTH-1:0] best_count;
    logic                   scan_step;
    logic                   scan_last;
    logic                   take;
    logic                   load_result;
    logic [COUNT_WIDTH-1:0] cand;

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state. Any snapshot restarts the scan, abandoning a scan
    // already in progress.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (snapshot) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (snapshot)       state_next = ST_SCAN;
                else if (scan_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = snapshot ? ST_SCAN : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs. The result registers are loaded on the final scan step so
    // the pulse and the new class/count appear together during DONE.
    always_comb begin
        scan_step   = (state == ST_SCAN);
        scan_last   = scan_step && (idx == CLASS_WIDTH'(CLASS_NUM-1));
        cand        = shadow[idx];
        take        = (cand > best_count);
        load_result = scan_last && !snapshot;
    end

    // Scan index and running best; strict compare keeps the lowest index.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx        <= '0;
            best_class <= '0;
            best_count <= '0;
        end else if (snapshot) begin
            idx        <= '0;
            best_class <= '0;
            best_count <= '0;
        end else if (scan_step) begin
            idx <= idx + 1'b1;
            if (take) begin
                best_class <= idx;
                best_count <= cand;
            end
        end
    end

    // Reported frame result.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_frame_valid <= 1'b0;
            out_frame_class <= '0;
            out_frame_count <= '0;
        end else begin
            out_frame_valid <= load_result;
            if (load_result) begin
                out_frame_class <= take ? idx  : best_class;
                out_frame_count <= take ? cand : best_count;
            end
        end
    end

`else

    assign out_frame_class = '0;
    assign out_frame_count = '0;
    assign out_frame_valid = 1'b0;

`endif

endmodule

// File: tb/tb_video_mnist_result_decoder.sv
`timescale 1ns/1ps
module tb_video_mnist_result_decoder;

    localparam int CN = 10;
    localparam int SW = 7;
    localparam int CW = 4;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [SW-1:0]    param_threshold;
    logic [0:0]       s_tuser;
    logic             s_tlast;
    logic [CN*SW-1:0] s_tdata;
    logic             s_tvalid;
    logic             s_tready;
    logic [0:0]       m_tuser;
    logic             m_tlast;
    logic [CW:0]      m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic [CW-1:0]    out_frame_class;
    logic [19:0]      out_frame_count;
    logic             out_frame_valid;

    always #5 aclk = ~aclk;

    video_mnist_result_decoder dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .param_threshold (param_threshold),
        .s_axi4s_tuser   (s_tuser),
        .s_axi4s_tlast   (s_tlast),
        .s_axi4s_tdata   (s_tdata),
        .s_axi4s_tvalid  (s_tvalid),
        .s_axi4s_tready  (s_tready),
        .m_axi4s_tuser   (m_tuser),
        .m_axi4s_tlast   (m_tlast),
        .m_axi4s_tdata   (m_tdata),
        .m_axi4s_tvalid  (m_tvalid),
        .m_axi4s_tready  (m_tready),
        .out_frame_class (out_frame_class),
        .out_frame_count (out_frame_count),
        .out_frame_valid (out_frame_valid)
    );

`ifdef VIDEO_MNIST_RESULT_DECODER_FRAME_VOTE_EN
    // Second instance with narrow counters to exercise saturation.
    logic          s_tready_s;
    logic [0:0]    m_tuser_s;
    logic          m_tlast_s;
    logic [CW:0]   m_tdata_s;
    logic          m_tvalid_s;
    logic [CW-1:0] out_frame_class_s;
    logic [2:0]    out_frame_count_s;
    logic          out_frame_valid_s;

    video_mnist_result_decoder #(.COUNT_WIDTH(3)) dut_sat (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .param_threshold (param_threshold),
        .s_axi4s_tuser   (s_tuser),
        .s_axi4s_tlast   (s_tlast),
        .s_axi4s_tdata   (s_tdata),
        .s_axi4s_tvalid  (s_tvalid),
        .s_axi4s_tready  (s_tready_s),
        .m_axi4s_tuser   (m_tuser_s),
        .m_axi4s_tlast   (m_tlast_s),
        .m_axi4s_tdata   (m_tdata_s),
        .m_axi4s_tvalid  (m_tvalid_s),
        .m_axi4s_tready  (m_tready),
        .out_frame_class (out_frame_class_s),
        .out_frame_count (out_frame_count_s),
        .out_frame_valid (out_frame_valid_s)
    );
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int       base;
        int       ia;
        int       va;
        int       ib;
        int       vb;
        int       thr;
        bit       sof;
        bit       eol;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        int cls;
        int cnt;
        int delta;
    } pulse_t;

    pulse_t pq[$];
    pulse_t pqs[$];
    int     cyc = 0;
    int     last_sof = -1000;
    int     last_sof_s = -1000;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [CN*SW-1:0] mkScores(input int base, input int ia,
                                                   input int va, input int ib,
                                                   input int vb);
        logic [CN*SW-1:0] d;
        for (int c = 0; c < CN; c++) d[c*SW +: SW] = SW'(base);
        if (ia >= 0) d[ia*SW +: SW] = SW'(va);
        if (ib >= 0) d[ib*SW +: SW] = SW'(vb);
        return d;
    endfunction

    task automatic applyStimulus(input logic [CN*SW-1:0] data, input bit sof,
                                 input bit eol, input bit valid);
        s_tdata  = data;
        s_tuser  = sof;
        s_tlast  = eol;
        s_tvalid = valid;
    endtask

    // Confident pixels score 100, non-confident 30 (threshold is 50).
    task automatic sendPixel(input int cls, input bit conf, input bit sof, input bit eol);
        @(negedge aclk);
        applyStimulus(mkScores(0, cls, conf ? 100 : 30, -1, 0), sof, eol, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge aclk);
            applyStimulus('0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic resetDut();
        @(negedge aclk);
        aresetn = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // Frame-result monitor: records every pulse with the distance (in
    // cycles) from the most recent SOF output handshake.
    always @(negedge aclk) begin
        cyc++;
        if (aresetn) begin
            if (m_tvalid && m_tready && m_tuser[0]) last_sof = cyc;
            if (out_frame_valid)
                pq.push_back('{int'(out_frame_class), int'(out_frame_count), cyc - last_sof});
`ifdef VIDEO_MNIST_RESULT_DECODER_FRAME_VOTE_EN
            if (m_tvalid_s && m_tready && m_tuser_s[0]) last_sof_s = cyc;
            if (out_frame_valid_s)
                pqs.push_back('{int'(out_frame_class_s), int'(out_frame_count_s), cyc - last_sof_s});
`endif
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[9];
        logic [5:0] q[$];
        logic [5:0] exp_beat;
        bit   pat[4];
        int   j;
        int   recv;
        int   fa_cls[12];
        bit   fa_conf[12];

        vecs[0] = '{5,  3, 100, -1,  0,  50, 1'b1, 1'b0, 5'b1_0011};
        vecs[1] = '{0,  2,  90,  7, 90,  50, 1'b0, 1'b1, 5'b1_0010};
        vecs[2] = '{10, 6,  40, -1,  0,  50, 1'b0, 1'b0, 5'b0_0110};
        vecs[3] = '{0, -1,   0, -1,  0,   0, 1'b0, 1'b0, 5'b1_0000};
        vecs[4] = '{126, 9, 127, -1, 0, 127, 1'b0, 1'b1, 5'b1_1001};
        vecs[5] = '{127, -1,  0, -1, 0, 127, 1'b0, 1'b0, 5'b1_0000};
        vecs[6] = '{0,  5,  49, -1,  0,  50, 1'b0, 1'b0, 5'b0_0101};
        vecs[7] = '{0,  1,  60,  0, 59,  50, 1'b0, 1'b0, 5'b1_0001};
        vecs[8] = '{0,  8,  80,  9, 80,  50, 1'b0, 1'b0, 5'b1_1000};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        param_threshold = 7'd50;
        m_tready        = 1'b1;
        applyStimulus('0, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(negedge aclk);
        checkOutput("rst_m_tvalid", m_tvalid, 0);
        checkOutput("rst_m_tdata", m_tdata, 0);
        checkOutput("rst_m_tuser", m_tuser, 0);
        checkOutput("rst_m_tlast", m_tlast, 0);
        checkOutput("rst_frame_valid", out_frame_valid, 0);
        checkOutput("rst_frame_class", out_frame_class, 0);
        checkOutput("rst_frame_count", out_frame_count, 0);
        aresetn = 1'b1;

        // Table vectors streamed back to back; result i appears two cycles later.
        for (int i = 0; i < 11; i++) begin
            @(negedge aclk);
            if (i >= 1 && i <= 9) param_threshold = SW'(vecs[i-1].thr);
            if (i < 9)
                applyStimulus(mkScores(vecs[i].base, vecs[i].ia, vecs[i].va,
                                       vecs[i].ib, vecs[i].vb),
                              vecs[i].sof, vecs[i].eol, 1'b1);
            else
                applyStimulus('0, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput("tbl_s_tready", s_tready, 1);
            if (i >= 2) begin
                checkOutput($sformatf("tbl%0d_tvalid", i-2), m_tvalid, 1);
                checkOutput($sformatf("tbl%0d_tdata", i-2), m_tdata, vecs[i-2].exp);
                checkOutput($sformatf("tbl%0d_tuser", i-2), m_tuser, vecs[i-2].sof);
                checkOutput($sformatf("tbl%0d_tlast", i-2), m_tlast, vecs[i-2].eol);
            end
        end
        @(negedge aclk);
        checkOutput("tbl_drain_tvalid", m_tvalid, 0);

        // Backpressure with tready pattern 1,0,0,1.
        param_threshold = 7'd50;
        j = 0;
        recv = 0;
        for (int t = 0; t < 200 && recv < 8; t++) begin
            @(negedge aclk);
            m_tready = pat[t % 4];
            if (j < 8) applyStimulus(mkScores(0, j, 100, -1, 0), 1'b0, j == 7, 1'b1);
            else       applyStimulus('0, 1'b0, 1'b0, 1'b0);
            #1;
            if (m_tvalid && !m_tready) checkOutput("bp_stall_s_tready", s_tready, 0);
            else                       checkOutput("bp_free_s_tready", s_tready, 1);
            if (s_tvalid && s_tready) begin
                q.push_back({j == 7, 1'b1, 4'(j)});
                j++;
            end
            if (m_tvalid && m_tready) begin
                if (q.size() == 0) begin
                    checkOutput("bp_unexpected_beat", 1, 0);
                end else begin
                    exp_beat = q.pop_front();
                    checkOutput($sformatf("bp%0d_tdata", recv), m_tdata, exp_beat[4:0]);
                    checkOutput($sformatf("bp%0d_tlast", recv), m_tlast, exp_beat[5]);
                end
                recv++;
            end
        end
        checkOutput("bp_received", recv, 8);
        checkOutput("bp_leftover", q.size(), 0);
        @(negedge aclk);
        m_tready = 1'b1;
        applyStimulus('0, 1'b0, 1'b0, 1'b0);

`ifdef VIDEO_MNIST_RESULT_DECODER_FRAME_VOTE_EN
        // Frame A: 6x class 8, 4x class 1, 2 non-confident; then SOF B.
        fa_cls  = '{8, 1, 8, 3, 1, 8, 8, 5, 1, 8, 1, 8};
        fa_conf = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1};
        resetDut();
        pq.delete();
        pqs.delete();
        for (int k = 0; k < 12; k++) sendPixel(fa_cls[k], fa_conf[k], k == 0, k == 11);
        sendPixel(3, 1'b1, 1'b1, 1'b0);
        idle(20);
        checkOutput("fa_pulses", pq.size(), 2);
        if (pq.size() >= 2) begin
            checkOutput("fa_first_class", pq[0].cls, 0);
            checkOutput("fa_first_count", pq[0].cnt, 0);
            checkOutput("fa_first_delay", pq[0].delta, 11);
            checkOutput("fa_class", pq[1].cls, 8);
            checkOutput("fa_count", pq[1].cnt, 6);
            checkOutput("fa_delay", pq[1].delta, 11);
        end
        checkOutput("fa_hold_class", out_frame_class, 8);
        checkOutput("fa_hold_count", out_frame_count, 6);
        checkOutput("fa_valid_low", out_frame_valid, 0);

        // Short frame: SOF C, two pixels, SOF D three cycles after C.
        pq.delete();
        sendPixel(5, 1'b1, 1'b1, 1'b0);
        sendPixel(5, 1'b1, 1'b0, 1'b0);
        sendPixel(5, 1'b1, 1'b0, 1'b0);
        sendPixel(0, 1'b0, 1'b1, 1'b0);
        idle(20);
        checkOutput("short_pulses", pq.size(), 1);
        if (pq.size() >= 1) begin
            checkOutput("short_class", pq[0].cls, 5);
            checkOutput("short_count", pq[0].cnt, 3);
            checkOutput("short_delay", pq[0].delta, 11);
        end

        // Saturation: 10 confident class-4 pixels, then the next SOF.
        pq.delete();
        pqs.delete();
        sendPixel(4, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) sendPixel(4, 1'b1, 1'b0, 1'b0);
        sendPixel(4, 1'b1, 1'b1, 1'b0);
        idle(20);
        checkOutput("sat_pulses", pqs.size(), 1);
        if (pqs.size() >= 1) begin
            checkOutput("sat_class", pqs[0].cls, 4);
            checkOutput("sat_count", pqs[0].cnt, 7);
            checkOutput("sat_delay", pqs[0].delta, 11);
        end
        checkOutput("wide_pulses", pq.size(), 1);
        if (pq.size() >= 1) begin
            checkOutput("wide_class", pq[0].cls, 4);
            checkOutput("wide_count", pq[0].cnt, 10);
        end
        checkOutput("sat_s_tready", s_tready_s, 1);

        // Reset asserted mid-scan: no pulse, everything cleared.
        pq.delete();
        pqs.delete();
        sendPixel(0, 1'b0, 1'b1, 1'b0);
        idle(6);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        checkOutput("mrst_m_tvalid", m_tvalid, 0);
        checkOutput("mrst_m_tdata", m_tdata, 0);
        checkOutput("mrst_class", out_frame_class, 0);
        checkOutput("mrst_count", out_frame_count, 0);
        checkOutput("mrst_sat_class", out_frame_class_s, 0);
        checkOutput("mrst_sat_count", out_frame_count_s, 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        idle(20);
        checkOutput("mrst_no_pulse", pq.size(), 0);
        checkOutput("mrst_sat_no_pulse", pqs.size(), 0);
        checkOutput("mrst_after_class", out_frame_class, 0);
        checkOutput("mrst_after_count", out_frame_count, 0);
        checkOutput("mrst_after_sat_count", out_frame_count_s, 0);
`else
        // Vote logic absent: SOFs went through but no frame result appears.
        fa_cls  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        fa_conf = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        sendPixel(2, 1'b1, 1'b1, 1'b0);
        sendPixel(2, 1'b1, 1'b0, 1'b0);
        sendPixel(3, 1'b1, 1'b1, 1'b0);
        idle(20);
        checkOutput("novote_pulses", pq.size(), 0);
        checkOutput("novote_class", out_frame_class, 0);
        checkOutput("novote_count", out_frame_count, 0);
        checkOutput("novote_valid", out_frame_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
